// File: rtl/mem_phase_responder_pkg.sv
// Shared encodings and constants for the MEM-phase data-memory responder.
package mem_phase_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int CNT_W    = 4;
  localparam int WORD_OFS = 2;

  function automatic logic is_misaligned(input logic [WORD_OFS-1:0] lsb);
    return lsb != '0;
  endfunction

endpackage

// File: rtl/mem_phase_responder_dmem_array.sv
// Single-port word array: synchronous write, registered read whose output holds
// until the next read strobe. Contents are not reset; only the read register is.
module mem_phase_responder_dmem_array #(
  parameter int IDX_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic              rd_zero_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**IDX_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // rd_zero_i lets the owner return a clean zero without touching the array
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= rd_zero_i ? '0 : mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_phase_responder.sv
// MEM-phase data-memory responder: accept, wait WAIT_CYCLES, access, pulse ready.
// Optional misaligned-access error reporting: MEM_PHASE_RESPONDER_MISALIGN_CHECK_EN.
//   state   | meaning
//   ST_IDLE | waiting for req; acceptance latches we/addr/wdata
//   ST_WAIT | counting wait states down to zero, inputs ignored
//   ST_RESP | ready pulse; array access happened on the entering edge
module mem_phase_responder
  import mem_phase_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int              IDX_W    = ADDR_W - WORD_OFS;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;

  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic                enter_resp;
  logic                mis;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accepting edge itself,
  // before the latches have captured the request, so bypass them from IDLE.
  assign acc_we     = (state_q == ST_IDLE) ? we    : we_q;
  assign acc_addr   = (state_q == ST_IDLE) ? addr  : addr_q;
  assign acc_wdata  = (state_q == ST_IDLE) ? wdata : wdata_q;
  assign enter_resp = !reset && (state_d == ST_RESP) && (state_q != ST_RESP);

`ifdef MEM_PHASE_RESPONDER_MISALIGN_CHECK_EN
  assign mis = is_misaligned(acc_addr[WORD_OFS-1:0]);
`else
  logic unused_addr_lsbs;
  assign mis              = 1'b0;
  assign unused_addr_lsbs = ^acc_addr[WORD_OFS-1:0];
`endif

  assign err_d = enter_resp ? mis : err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  mem_phase_responder_dmem_array #(
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (enter_resp && acc_we && !mis),
    .rd_en_i   (enter_resp && !acc_we),
    .rd_zero_i (mis),
    .idx_i     (acc_addr[ADDR_W-1:WORD_OFS]),
    .wdata_i   (acc_wdata),
    .rdata_o   (rdata)
  );

  assign ready = (state_q == ST_RESP);
  assign busy  = (state_q != ST_IDLE);
  assign err   = err_q;

endmodule

// File: tb/tb_mem_phase_responder.sv
// Bench for mem_phase_responder: transaction-level model checked every cycle
// on a WAIT_CYCLES=2 instance, plus directed timing checks on a WAIT_CYCLES=0 instance.
`timescale 1ns/1ps
module tb_mem_phase_responder;

  localparam int W = 2;
`ifdef MEM_PHASE_RESPONDER_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready, busy, err;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [9:0]  addr0 = '0;
  logic [31:0] wdata0 = '0;
  logic [31:0] rdata0;
  logic        ready0, busy0, err0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_phase_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .busy(busy), .err(err));

  mem_phase_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction model: a request accepted at edge e completes at edge e+W,
  // ready is high for the cycle after that, and the responder is free again one edge later.
  logic [31:0] m_mem [256];
  bit          m_known [256];
  bit          m_active, m_resp, m_rknown, m_err, chk_en;
  int          e = 0, acc_e = 0;
  logic        m_lwe;
  logic [9:0]  m_laddr;
  logic [31:0] m_lwd, m_rdata;

  always @(posedge clk) begin
    e++;
    if (reset) begin
      m_active = 0; m_resp = 0; m_rdata = '0; m_rknown = 1; m_err = 0; chk_en = 1;
    end else begin
      if (m_resp) begin
        m_resp = 0; m_active = 0;
      end else if (!m_active && req) begin
        m_active = 1; acc_e = e; m_lwe = we; m_laddr = addr; m_lwd = wdata;
      end
      if (m_active && !m_resp && e == acc_e + W) begin
        automatic bit mis = MIS_EN && (m_laddr % 4 != 0);
        automatic int idx = int'(m_laddr) / 4;
        m_err = mis;
        if (m_lwe) begin
          if (!mis) begin m_mem[idx] = m_lwd; m_known[idx] = 1; end
        end else if (mis) begin
          m_rdata = '0; m_rknown = 1;
        end else begin
          m_rdata = m_mem[idx]; m_rknown = m_known[idx];
        end
        m_resp = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {31'b0, ready}, {31'b0, m_resp});
      check("busy", {31'b0, busy}, {31'b0, m_active});
      check("err", {31'b0, err}, {31'b0, m_err});
      if (m_rknown) check("rdata", rdata, m_rdata);
    end
  end

  task automatic txn(input logic w, input logic [9:0] a, input logic [31:0] d, output int lat);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready && lat < 40);
    if (!ready) begin
      checks++; failures++;
      $display("FAIL txn_timeout addr=%h actual=no_ready required=ready", a);
    end
    req = 1'b0;
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_rdata", rdata, 32'h0);
    reset = 1'b0;

    txn(1'b1, 10'h010, 32'hDEADBEEF, lat);
    check("lat_write_w2", lat, 32'd3);
    txn(1'b0, 10'h010, 32'h0, lat);
    check("lat_read_w2", lat, 32'd3);
    check("read_010", rdata, 32'hDEADBEEF);

    txn(1'b1, 10'h000, 32'h0BADF00D, lat);
    txn(1'b1, 10'h3FC, 32'h12345678, lat);
    txn(1'b0, 10'h000, 32'h0, lat);
    check("read_000", rdata, 32'h0BADF00D);
    txn(1'b0, 10'h3FC, 32'h0, lat);
    check("read_3fc", rdata, 32'h12345678);
    txn(1'b1, 10'h000, 32'h00000000, lat);
    check("rdata_hold_over_write", rdata, 32'h12345678);

    // reset during the first wait cycle aborts the write
    txn(1'b1, 10'h020, 32'h55AA55AA, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 10'h020; wdata = 32'hAAAA5555;
    @(negedge clk);
    check("abort_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1; req = 1'b0;
    @(negedge clk);
    check("abort_busy_after", {31'b0, busy}, 32'd0);
    check("abort_ready_after", {31'b0, ready}, 32'd0);
    reset = 1'b0;
    txn(1'b0, 10'h020, 32'h0, lat);
    check("abort_read_020", rdata, 32'h55AA55AA);

    // reset in the same cycle as req wins
    @(negedge clk);
    reset = 1'b1; req = 1'b1; we = 1'b1; addr = 10'h020; wdata = 32'hFFFF0000;
    @(negedge clk);
    reset = 1'b0; req = 1'b0;
    @(negedge clk);
    check("reset_req_busy", {31'b0, busy}, 32'd0);
    txn(1'b0, 10'h020, 32'h0, lat);
    check("reset_req_read_020", rdata, 32'h55AA55AA);

    // inputs changed during WAIT have no effect
    txn(1'b1, 10'h040, 32'h11111111, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 10'h020; wdata = 32'h0000000F;
    @(negedge clk);
    addr = 10'h040; wdata = 32'hFFFFFFFF;
    lat = 1;
    while (!ready && lat < 40) begin @(negedge clk); lat++; end
    check("latch_lat", lat, 32'd3);
    req = 1'b0;
    txn(1'b0, 10'h040, 32'h0, lat);
    check("latch_read_040", rdata, 32'h11111111);
    txn(1'b0, 10'h020, 32'h0, lat);
    check("latch_read_020", rdata, 32'h0000000F);

    // misaligned accesses
    txn(1'b1, 10'h021, 32'hA5A5A5A5, lat);
    check("mis_write_err", {31'b0, err}, {31'b0, MIS_EN});
    check("mis_write_lat", lat, 32'd3);
    txn(1'b0, 10'h020, 32'h0, lat);
    check("mis_word_020", rdata, MIS_EN ? 32'h0000000F : 32'hA5A5A5A5);
    check("aligned_err", {31'b0, err}, 32'd0);
    txn(1'b0, 10'h022, 32'h0, lat);
    check("mis_read_rdata", rdata, MIS_EN ? 32'h0 : 32'hA5A5A5A5);
    check("mis_read_err", {31'b0, err}, {31'b0, MIS_EN});

    // zero wait states: ready the cycle after acceptance, every 2 cycles when held
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h004; wdata0 = 32'hCAFEF00D;
    @(negedge clk);
    check("w0_write_ready", {31'b0, ready0}, 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    check("w0_idle_busy", {31'b0, busy0}, 32'd0);
    req0 = 1'b1; we0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("w0_ready_pattern", {31'b0, ready0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("w0_busy_pattern", {31'b0, busy0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("w0_rdata", rdata0, 32'hCAFEF00D);
      check("w0_err", {31'b0, err0}, 32'd0);
    end
    req0 = 1'b0;

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
